ternary_cam_pipelined: RTL and testbench
========================================

# ternary_cam_pipelined

Parametrised ternary CAM with per-entry stored don't-care masks, valid bits and a two-stage search pipeline. Commands use a valid/ready handshake; results carry a match vector, a lowest-index priority address, a hit flag and a match count, with output backpressure. Drop-in successor to the single-cycle TCAM for lookup tables where entries must be invalidated and searches must be pipelined.

## Interface
- WORD_SIZE, 8, bits per entry and per key
- ADDRESS_SIZE, 4, log2 of entry count; DEPTH = 1 << ADDRESS_SIZE
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  block accepts command this cycle
- cmd_op  in  2  00 clear-all, 01 write, 10 invalidate, 11 search
- cmd_address  in  ADDRESS_SIZE  target entry (write/invalidate)
- cmd_word  in  WORD_SIZE  entry value (write) or search key
- cmd_mask  in  WORD_SIZE  bit 1 = don't care; stored mask (write) or key mask (search)
- result_valid  out  1  search result present
- result_ready  in  1  consumer accepts result
- result_matched  out  DEPTH  bit i set when entry i matches
- result_hit  out  1  any entry matched
- result_address  out  ADDRESS_SIZE  lowest matching index, 0 when no hit
- result_count  out  ADDRESS_SIZE+1  number of matching entries

## Operation
- Accept: cmd_valid && cmd_ready at a rising edge.
- cmd_ready = !(result_valid && !result_ready), combinational; high during and after reset.
- Write: entry[address] <= {valid=1, value=word, mask=mask} at the accepting edge.
- Invalidate: valid[address] <= 0; value/mask untouched.
- Clear-all: all valid bits <= 0 in one edge.
- Search: key/key-mask captured into stage-1 register (s1_valid set).
- Match rule, entry i: valid[i] && for every bit j: stored_mask[i][j] | key_mask[j] | (value[i][j] == key[j]).
- Fully masked key matches every valid entry; invalid entries never match.
- Stage 1 -> stage 2: when s1_valid and not stalled, match vector registered into stage 2; stage 2 drives result_* registered, count and priority address computed from the registered vector and registered with it.
- Ordering: a search observes every write/invalidate/clear accepted before it and none accepted after it. Guaranteed because writes commit at acceptance and stage 1 compares on the following edge, and nothing is accepted during a stall.
- Stall: while result_valid && !result_ready, result_* hold stable, stage 1 holds, no commands accepted.
- Result consumed when result_valid && result_ready; result_valid drops next edge unless a new result advances in the same edge.
- Write to an address while a search for it is in stage 1: search sees the pre-write contents.

## Timing
- Search latency: accepted at edge N -> result_valid at edge N+2 (no stall).
- Throughput: one command per cycle, any op mix, when result_ready held high.
- Write visible to a search accepted at edge N+1 or later.
- Reset (async, any time, including mid-search): all valid bits 0, s1_valid 0, result_valid 0, result_matched 0, result_hit 0, result_address 0, result_count 0; in-flight searches discarded. Stored value/mask arrays need no reset.
- count arithmetic: unsigned, width ADDRESS_SIZE+1 so DEPTH matches (all set) gives count = DEPTH without wrap.

## Structure
- Package tcam_pkg: op encoding constants (OP_CLEAR, OP_WRITE, OP_INVALIDATE, OP_SEARCH), DEPTH derivation.
- Sub-module tcam_priority_encoder: DEPTH-bit vector in -> lowest set index, hit, popcount; purely combinational, parametrised by ADDRESS_SIZE.
- Top holds entry arrays, valid bits, stage registers, handshake logic.

## Test plan
- Reset, write entry 3 = 0xA5 mask 0x00, search 0xA5 mask 0x00 -> two edges later result_valid, matched = 0x0008, hit 1, address 3, count 1.
- Write entry 1 = 0xA0 mask 0x0F and entry 6 = 0xA5 mask 0x00, search 0xA5 -> matched 0x0042, address 1, count 2; search 0xAF -> matched 0x0002.
- Search key mask 0xFF with entries 0, 2, 15 valid -> matched 0x8005, count 3; after clear-all, same search -> hit 0, address 0, count 0.
- Back-to-back: write entry 4 = 0x11, then search 0x11 next cycle -> hit address 4; search 0x22 then write entry 5 = 0x22 next cycle -> that search misses.
- Hold result_ready low 3 cycles with a result pending -> cmd_ready low, result_* stable, no write takes effect; release -> queued stage-1 result appears the following edge.
- Assert reset while a search is in stage 1 -> result_valid never rises, all outputs 0, all entries invalid (subsequent search of 0x00 mask 0xFF misses).

Source files
------------

// File: rtl/tcam_pkg.sv
// Shared op encodings and geometry helpers for the pipelined ternary CAM.
package tcam_pkg;

   localparam logic [1:0] OP_CLEAR      = 2'b00;
   localparam logic [1:0] OP_WRITE      = 2'b01;
   localparam logic [1:0] OP_INVALIDATE = 2'b10;
   localparam logic [1:0] OP_SEARCH     = 2'b11;

   function automatic int depth_of(input int address_size);
      return 1 << address_size;
   endfunction

endpackage

// File: rtl/tcam_priority_encoder.sv
// Lowest-index priority encoder with hit flag and population count.
module tcam_priority_encoder
   import tcam_pkg::*;
#(
   parameter int ADDRESS_SIZE = 4
) (
   input  logic [depth_of(ADDRESS_SIZE)-1:0] vec,
   output logic                              hit,
   output logic [ADDRESS_SIZE-1:0]           address,
   output logic [ADDRESS_SIZE:0]             count
);

   localparam int DEPTH = depth_of(ADDRESS_SIZE);

   // Scan downward so the last assignment wins with the lowest set index.
   always_comb begin
      hit     = 1'b0;
      address = '0;
      count   = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (vec[i]) begin
            hit     = 1'b1;
            address = i[ADDRESS_SIZE-1:0];
         end
      end
      for (int i = 0; i < DEPTH; i++)
         count = count + (ADDRESS_SIZE + 1)'(vec[i]);
   end

endmodule

// File: rtl/ternary_cam_pipelined.sv
// Ternary CAM with per-entry masks, valid bits and a registered search pipeline
// (key register -> match-vector register -> result register).
module ternary_cam_pipelined
   import tcam_pkg::*;
#(
   parameter int WORD_SIZE    = 8,
   parameter int ADDRESS_SIZE = 4
) (
   input  logic                              clock,
   input  logic                              reset,
   input  logic                              cmd_valid,
   output logic                              cmd_ready,
   input  logic [1:0]                        cmd_op,
   input  logic [ADDRESS_SIZE-1:0]           cmd_address,
   input  logic [WORD_SIZE-1:0]              cmd_word,
   input  logic [WORD_SIZE-1:0]              cmd_mask,
   output logic                              result_valid,
   input  logic                              result_ready,
   output logic [depth_of(ADDRESS_SIZE)-1:0] result_matched,
   output logic                              result_hit,
   output logic [ADDRESS_SIZE-1:0]           result_address,
   output logic [ADDRESS_SIZE:0]             result_count
);

   localparam int DEPTH = depth_of(ADDRESS_SIZE);

   logic [WORD_SIZE-1:0]    value_q [DEPTH];
   logic [WORD_SIZE-1:0]    mask_q  [DEPTH];
   logic [DEPTH-1:0]        valid_q;

   logic                    s1_valid;
   logic [WORD_SIZE-1:0]    s1_key;
   logic [WORD_SIZE-1:0]    s1_mask;
   logic                    s2_valid;
   logic [DEPTH-1:0]        s2_matched;

   logic [DEPTH-1:0]        match_vec;
   logic                    stall;
   logic                    accept;
   logic                    enc_hit;
   logic [ADDRESS_SIZE-1:0] enc_address;
   logic [ADDRESS_SIZE:0]   enc_count;

   assign stall     = result_valid && !result_ready;
   assign cmd_ready = !stall;
   assign accept    = cmd_valid && cmd_ready;

   // Compare against the array as it stands before this edge's write commits,
   // so a search always sees exactly the commands accepted ahead of it.
   for (genvar i = 0; i < DEPTH; i++) begin : g_match
      assign match_vec[i] = valid_q[i] &
                            (&(mask_q[i] | s1_mask | ~(value_q[i] ^ s1_key)));
   end

   always_ff @(posedge clock) begin
      if (accept && cmd_op == OP_WRITE) begin
         value_q[cmd_address] <= cmd_word;
         mask_q[cmd_address]  <= cmd_mask;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         valid_q <= '0;
      end else if (accept) begin
         case (cmd_op)
            OP_CLEAR:      valid_q              <= '0;
            OP_WRITE:      valid_q[cmd_address] <= 1'b1;
            OP_INVALIDATE: valid_q[cmd_address] <= 1'b0;
            default:       ;
         endcase
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         s1_valid   <= 1'b0;
         s1_key     <= '0;
         s1_mask    <= '0;
         s2_valid   <= 1'b0;
         s2_matched <= '0;
      end else if (!stall) begin
         s1_valid <= accept && cmd_op == OP_SEARCH;
         if (accept && cmd_op == OP_SEARCH) begin
            s1_key  <= cmd_word;
            s1_mask <= cmd_mask;
         end
         s2_valid <= s1_valid;
         if (s1_valid)
            s2_matched <= match_vec;
      end
   end

   tcam_priority_encoder #(
      .ADDRESS_SIZE(ADDRESS_SIZE)
   ) u_encoder (
      .vec     (s2_matched),
      .hit     (enc_hit),
      .address (enc_address),
      .count   (enc_count)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         result_valid   <= 1'b0;
         result_matched <= '0;
         result_hit     <= 1'b0;
         result_address <= '0;
         result_count   <= '0;
      end else if (!stall) begin
         result_valid <= s2_valid;
         if (s2_valid) begin
            result_matched <= s2_matched;
            result_hit     <= enc_hit;
            result_address <= enc_address;
            result_count   <= enc_count;
         end
      end
   end

endmodule

// File: tb/tb_ternary_cam_pipelined.sv
// Directed vector table plus hand sequences for the pipelined ternary CAM.
module tb_ternary_cam_pipelined;
   import tcam_pkg::*;

   logic        clock = 1'b0;
   logic        reset;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [1:0]  cmd_op;
   logic [3:0]  cmd_address;
   logic [7:0]  cmd_word;
   logic [7:0]  cmd_mask;
   logic        result_valid;
   logic        result_ready;
   logic [15:0] result_matched;
   logic        result_hit;
   logic [3:0]  result_address;
   logic [4:0]  result_count;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [1:0]  op;
      logic [3:0]  addr;
      logic [7:0]  word;
      logic [7:0]  mask;
      logic [15:0] exp_matched;
      logic        exp_hit;
      logic [3:0]  exp_address;
      logic [4:0]  exp_count;
   } vec_t;

   vec_t tbl[$];

   ternary_cam_pipelined dut (
      .clock          (clock),
      .reset          (reset),
      .cmd_valid      (cmd_valid),
      .cmd_ready      (cmd_ready),
      .cmd_op         (cmd_op),
      .cmd_address    (cmd_address),
      .cmd_word       (cmd_word),
      .cmd_mask       (cmd_mask),
      .result_valid   (result_valid),
      .result_ready   (result_ready),
      .result_matched (result_matched),
      .result_hit     (result_hit),
      .result_address (result_address),
      .result_count   (result_count)
   );

   always #5 clock = ~clock;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [1:0] op, input logic [3:0] a, input logic [7:0] w,
                               input logic [7:0] m, input logic [15:0] em, input logic eh,
                               input logic [3:0] ea, input logic [4:0] ec);
      vec_t v;
      v.op = op; v.addr = a; v.word = w; v.mask = m;
      v.exp_matched = em; v.exp_hit = eh; v.exp_address = ea; v.exp_count = ec;
      return v;
   endfunction

   task automatic drive(input logic [1:0] op, input logic [3:0] a, input logic [7:0] w,
                        input logic [7:0] m);
      cmd_valid = 1'b1; cmd_op = op; cmd_address = a; cmd_word = w; cmd_mask = m;
   endtask

   // Issue one command on an idle bus; returns at the negedge after acceptance.
   task automatic do_cmd(input string name, input logic [1:0] op, input logic [3:0] a,
                         input logic [7:0] w, input logic [7:0] m);
      @(negedge clock);
      drive(op, a, w, m);
      chk({name, ".cmd_ready"}, cmd_ready, 1);
      @(negedge clock);
      cmd_valid = 1'b0;
   endtask

   task automatic chk_result(input string name, input logic [15:0] em, input logic eh,
                             input logic [3:0] ea, input logic [4:0] ec);
      chk({name, ".valid"},   result_valid,   1);
      chk({name, ".matched"}, result_matched, em);
      chk({name, ".hit"},     result_hit,     eh);
      chk({name, ".address"}, result_address, ea);
      chk({name, ".count"},   result_count,   ec);
   endtask

   task automatic search_check(input string name, input logic [7:0] key, input logic [7:0] km,
                               input logic [15:0] em, input logic eh, input logic [3:0] ea,
                               input logic [4:0] ec);
      do_cmd(name, OP_SEARCH, 4'd0, key, km);
      @(negedge clock);
      chk({name, ".early"}, result_valid, 0);
      @(negedge clock);
      chk_result(name, em, eh, ea, ec);
   endtask

   initial begin
      reset = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_address = '0;
      cmd_word = '0; cmd_mask = '0; result_ready = 1'b1;

      tbl.push_back(mk(OP_WRITE,      4'd3,  8'hA5, 8'h00, 16'h0000, 0, 4'd0, 5'd0));
      tbl.push_back(mk(OP_SEARCH,     4'd0,  8'hA5, 8'h00, 16'h0008, 1, 4'd3, 5'd1));
      tbl.push_back(mk(OP_CLEAR,      4'd0,  8'h00, 8'h00, 16'h0000, 0, 4'd0, 5'd0));
      tbl.push_back(mk(OP_WRITE,      4'd1,  8'hA0, 8'h0F, 16'h0000, 0, 4'd0, 5'd0));
      tbl.push_back(mk(OP_WRITE,      4'd6,  8'hA5, 8'h00, 16'h0000, 0, 4'd0, 5'd0));
      tbl.push_back(mk(OP_SEARCH,     4'd0,  8'hA5, 8'h00, 16'h0042, 1, 4'd1, 5'd2));
      tbl.push_back(mk(OP_SEARCH,     4'd0,  8'hAF, 8'h00, 16'h0002, 1, 4'd1, 5'd1));
      tbl.push_back(mk(OP_CLEAR,      4'd0,  8'h00, 8'h00, 16'h0000, 0, 4'd0, 5'd0));
      tbl.push_back(mk(OP_WRITE,      4'd0,  8'h12, 8'h00, 16'h0000, 0, 4'd0, 5'd0));
      tbl.push_back(mk(OP_WRITE,      4'd2,  8'h34, 8'h00, 16'h0000, 0, 4'd0, 5'd0));
      tbl.push_back(mk(OP_WRITE,      4'd15, 8'h56, 8'h00, 16'h0000, 0, 4'd0, 5'd0));
      tbl.push_back(mk(OP_SEARCH,     4'd0,  8'h00, 8'hFF, 16'h8005, 1, 4'd0, 5'd3));
      tbl.push_back(mk(OP_INVALIDATE, 4'd2,  8'h00, 8'h00, 16'h0000, 0, 4'd0, 5'd0));
      tbl.push_back(mk(OP_SEARCH,     4'd0,  8'h00, 8'hFF, 16'h8001, 1, 4'd0, 5'd2));
      tbl.push_back(mk(OP_SEARCH,     4'd0,  8'h56, 8'h00, 16'h8000, 1, 4'd15, 5'd1));
      tbl.push_back(mk(OP_CLEAR,      4'd0,  8'h00, 8'h00, 16'h0000, 0, 4'd0, 5'd0));
      tbl.push_back(mk(OP_SEARCH,     4'd0,  8'h00, 8'hFF, 16'h0000, 0, 4'd0, 5'd0));
      for (int i = 0; i < 16; i++)
         tbl.push_back(mk(OP_WRITE, 4'(i), 8'(i), 8'h00, 16'h0000, 0, 4'd0, 5'd0));
      tbl.push_back(mk(OP_SEARCH,     4'd0,  8'h00, 8'hFF, 16'hFFFF, 1, 4'd0, 5'd16));
      tbl.push_back(mk(OP_SEARCH,     4'd0,  8'h03, 8'h00, 16'h0008, 1, 4'd3, 5'd1));
      tbl.push_back(mk(OP_SEARCH,     4'd0,  8'h0C, 8'h03, 16'hF000, 1, 4'd12, 5'd4));
      tbl.push_back(mk(OP_SEARCH,     4'd0,  8'h10, 8'h00, 16'h0000, 0, 4'd0, 5'd0));
      tbl.push_back(mk(OP_WRITE,      4'd5,  8'hEE, 8'hFF, 16'h0000, 0, 4'd0, 5'd0));
      tbl.push_back(mk(OP_SEARCH,     4'd0,  8'h77, 8'h00, 16'h0020, 1, 4'd5, 5'd1));

      // Reset state
      @(negedge clock);
      @(negedge clock);
      chk("rst.cmd_ready", cmd_ready, 1);
      chk("rst.valid", result_valid, 0);
      chk("rst.matched", result_matched, 0);
      chk("rst.hit", result_hit, 0);
      chk("rst.address", result_address, 0);
      chk("rst.count", result_count, 0);
      reset = 1'b0;

      foreach (tbl[k]) begin
         if (tbl[k].op == OP_SEARCH)
            search_check($sformatf("v%0d", k), tbl[k].word, tbl[k].mask, tbl[k].exp_matched,
                         tbl[k].exp_hit, tbl[k].exp_address, tbl[k].exp_count);
         else
            do_cmd($sformatf("v%0d", k), tbl[k].op, tbl[k].addr, tbl[k].word, tbl[k].mask);
      end

      // Back-to-back: write then search sees it; search then write does not.
      do_cmd("b2b.clr", OP_CLEAR, 4'd0, 8'h00, 8'h00);
      drive(OP_WRITE, 4'd4, 8'h11, 8'h00);
      @(negedge clock);
      drive(OP_SEARCH, 4'd0, 8'h11, 8'h00);
      @(negedge clock);
      drive(OP_SEARCH, 4'd0, 8'h22, 8'h00);
      @(negedge clock);
      drive(OP_WRITE, 4'd5, 8'h22, 8'h00);
      @(negedge clock);
      cmd_valid = 1'b0;
      chk_result("b2b.s11", 16'h0010, 1, 4'd4, 5'd1);
      @(negedge clock);
      chk_result("b2b.s22", 16'h0000, 0, 4'd0, 5'd0);
      search_check("b2b.after", 8'h22, 8'h00, 16'h0020, 1, 4'd5, 5'd1);

      // Stall with a result pending and a second search queued behind it.
      do_cmd("st.clr", OP_CLEAR, 4'd0, 8'h00, 8'h00);
      do_cmd("st.w7", OP_WRITE, 4'd7, 8'h3C, 8'h00);
      do_cmd("st.w9", OP_WRITE, 4'd9, 8'h55, 8'h00);
      result_ready = 1'b0;
      drive(OP_SEARCH, 4'd0, 8'h3C, 8'h00);
      @(negedge clock);
      drive(OP_SEARCH, 4'd0, 8'h00, 8'hFF);
      @(negedge clock);
      cmd_valid = 1'b0;
      @(negedge clock);
      chk_result("st.first", 16'h0080, 1, 4'd7, 5'd1);
      chk("st.ready0", cmd_ready, 0);
      drive(OP_WRITE, 4'd7, 8'h00, 8'h00);
      for (int c = 0; c < 3; c++) begin
         @(negedge clock);
         chk($sformatf("st.hold%0d.ready", c), cmd_ready, 0);
         chk_result($sformatf("st.hold%0d", c), 16'h0080, 1, 4'd7, 5'd1);
      end
      cmd_valid = 1'b0;
      result_ready = 1'b1;
      @(negedge clock);
      chk_result("st.second", 16'h0280, 1, 4'd7, 5'd2);
      @(negedge clock);
      chk("st.drain", result_valid, 0);
      search_check("st.nowrite", 8'h3C, 8'h00, 16'h0080, 1, 4'd7, 5'd1);

      // Reset while a search sits in stage 1.
      do_cmd("rs.w2", OP_WRITE, 4'd2, 8'h00, 8'h00);
      @(negedge clock);
      drive(OP_SEARCH, 4'd0, 8'h00, 8'hFF);
      @(negedge clock);
      cmd_valid = 1'b0;
      reset = 1'b1;
      #1;
      chk("rs.valid", result_valid, 0);
      chk("rs.matched", result_matched, 0);
      chk("rs.hit", result_hit, 0);
      chk("rs.address", result_address, 0);
      chk("rs.count", result_count, 0);
      chk("rs.cmd_ready", cmd_ready, 1);
      @(negedge clock);
      reset = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clock);
         chk($sformatf("rs.quiet%0d", c), result_valid, 0);
      end
      search_check("rs.empty", 8'h00, 8'hFF, 16'h0000, 0, 4'd0, 5'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
